store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of store entries; power of two, 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stWrEn  input  1  pipeline store request this cycle.
REQ-005 stAddr  input  32  store byte address; bits [1:0] ignored.
REQ-006 stData  input  32  store word.
REQ-007 ldRdEn  input  1  pipeline load request this cycle.
REQ-008 ldAddr  input  32  load byte address; bits [1:0] ignored.
REQ-009 memDataOut  input  32  combinational read data from data memory at memRdAddress.
REQ-010 memReady  input  1  data-memory write port available this cycle.
REQ-011 memWriteEn  output  1  write strobe to data memory.
REQ-012 memAddress  output  32  write address to data memory, {head word address, 2'b00}.
REQ-013 memDataIn  output  32  write data to data memory.
REQ-014 memRdAddress  output  32  {ldAddr[31:2], 2'b00}.
REQ-015 ldData  output  32  load result to pipeline.
REQ-016 stall  output  1  pipeline must hold the MEM-stage instruction this cycle.
REQ-017 full  output  1  count == DEPTH.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Circular FIFO: head pointer, tail pointer, count (width log2(DEPTH)+1); each entry holds a 30-bit word address and a 32-bit data word; pointers wrap from DEPTH-1 to 0.
REQ-020 Push: stWrEn=1 and count<DEPTH at the edge -> write {stAddr[31:2], stData} at tail and increment tail.
REQ-021 Push is evaluated against the pre-edge count; stWrEn=1 while full is rejected and asserts stall, even if a drain occurs in the same cycle.
REQ-022 Drain: memWriteEn = !empty & memReady, combinational; memAddress and memDataIn are driven from the head entry; head increments at the same edge the memory captures the write.
REQ-023 Simultaneous push and drain: count unchanged, both pointers advance.
REQ-024 Store ordering: entries drain strictly in push order; no coalescing; a repeated address occupies two entries.
REQ-025 Load miss (no valid entry matches ldAddr[31:2]): ldData = memDataOut, combinational, zero latency.
REQ-026 The head entry being drained in the current cycle still counts as valid for matching.
REQ-027 stall = (stWrEn & full) | ldStall, where ldStall is defined in REQ-033.
REQ-028 stWrEn and ldRdEn both high in one cycle is illegal; behaviour is unspecified and the bench does not drive it.
REQ-029 ldData = 0 when ldRdEn = 0.

Reset
REQ-030 rst=1 at the edge: head=0, tail=0, count=0; entry contents are don't-care.
REQ-031 Output values during and after reset: empty=1, full=0, memWriteEn=0, stall=0.
REQ-032 rst overrides any push or drain in the same cycle; stores pending when reset is applied are discarded and never written.

Configuration
REQ-033 Macro SB_FORWARD_EN.
- Defined, load hit: ldData = data of the youngest matching entry (nearest tail), ldStall=0.
- Undefined, load hit: ldStall=1 and ldData = memDataOut (not consumed by the pipeline) until no matching entry remains; then the load completes as a miss.
- Load misses behave identically with or without the macro.

Verification
REQ-034 After reset, memReady=0, push 0x1000/0xAAAA0001 and 0x1004/0xBBBB0002 -> count=2, memWriteEn=0; then memReady=1 -> two consecutive cycles of memWriteEn with 0x1000/0xAAAA0001 then 0x1004/0xBBBB0002, then empty=1.
REQ-035 DEPTH=4, memReady=0, push 5 stores -> full=1 after the 4th push; 5th push gives stall=1 and count stays 4; raise memReady with 5th held -> 5th store accepted the cycle after the first drain.
REQ-036 With forwarding: push 0x2000/0x11 then 0x2000/0x22 (memReady=0), load 0x2002 -> ldData=0x22, stall=0.
REQ-037 Without forwarding, same stimulus -> stall=1 until both entries drain, then ldData=memDataOut.
REQ-038 Push 3 entries, assert rst for one cycle with memReady=1 -> no memWriteEn pulses after reset, empty=1.
REQ-039 Pointer wrap, DEPTH=4: push/drain 10 stores to 0x3000+4*i with data i -> memory writes occur in order 0..9 and count never exceeds 4.

Source files
------------

// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// Store buffer: circular FIFO of pending word stores draining to data memory, with load hit detection.
// Optional feature macro SB_FORWARD_EN: forward the youngest matching store to loads instead of stalling.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stWrEn,
  input  logic [31:0] stAddr,
  input  logic [31:0] stData,
  input  logic        ldRdEn,
  input  logic [31:0] ldAddr,
  input  logic [31:0] memDataOut,
  input  logic        memReady,
  output logic        memWriteEn,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  output logic [31:0] memRdAddress,
  output logic [31:0] ldData,
  output logic        stall,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WAW = 30;
  localparam int unsigned DW  = 32;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WAW-1:0] addr_q [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_c, full_c, push_c, drain_c;
  logic hit_c, ld_stall_c;
  logic [AW-1:0] idx_c;
`ifdef SB_FORWARD_EN
  logic [DW-1:0] fwd_data_c;
`endif

  // Address low bits select bytes within a word and play no part in matching.
  logic unused_c;
  assign unused_c = ^{stAddr[1:0], ldAddr[1:0]};

  // Occupancy and handshake; reset masks any push or drain in flight.
  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == DEPTH_C);
    drain_c = !rst && !empty_c && memReady;
    push_c  = !rst && stWrEn && !full_c;
  end

  // Next-state pointers and count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain_c) head_d = head_q + AW'(1);
    if (push_c)  tail_d = tail_q + AW'(1);
    if (push_c && !drain_c)      count_d = count_q + CW'(1);
    else if (!push_c && drain_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[tail_q] <= stAddr[31:2];
      data_q[tail_q] <= stData;
    end
  end

  // Scan oldest to youngest so the youngest match wins; the head being drained still counts.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
`ifdef SB_FORWARD_EN
    fwd_data_c = '0;
`endif
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      idx_c = tail_q - AW'(k) - AW'(1);
      if ((CW'(k) < count_q) && (addr_q[idx_c] == ldAddr[31:2])) begin
        hit_c = 1'b1;
`ifdef SB_FORWARD_EN
        fwd_data_c = data_q[idx_c];
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  always_comb begin
    ld_stall_c = 1'b0;
    ldData     = '0;
    if (ldRdEn) ldData = hit_c ? fwd_data_c : memDataOut;
  end
`else
  // Without forwarding a hit waits until every matching store has reached memory.
  always_comb begin
    ld_stall_c = ldRdEn && hit_c;
    ldData     = '0;
    if (ldRdEn) ldData = memDataOut;
  end
`endif

  assign memWriteEn   = drain_c;
  assign memAddress   = {addr_q[head_q], 2'b00};
  assign memDataIn    = data_q[head_q];
  assign memRdAddress = {ldAddr[31:2], 2'b00};
  assign stall        = !rst && ((stWrEn && full_c) || ld_stall_c);
  assign full         = !rst && full_c;
  assign empty        = rst || empty_c;

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for store_buffer: vector table for fill/drain/full, scoreboard for memory writes and loads.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stWrEn, ldRdEn, memReady;
  logic [31:0] stAddr, stData, ldAddr, memDataOut;
  logic        memWriteEn, stall, full, empty;
  logic [31:0] memAddress, memDataIn, memRdAddress, ldData;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stWrEn(stWrEn), .stAddr(stAddr), .stData(stData),
    .ldRdEn(ldRdEn), .ldAddr(ldAddr), .memDataOut(memDataOut), .memReady(memReady),
    .memWriteEn(memWriteEn), .memAddress(memAddress), .memDataIn(memDataIn),
    .memRdAddress(memRdAddress), .ldData(ldData), .stall(stall), .full(full), .empty(empty)
  );

  // Simple data-memory read model.
  assign memDataOut = memRdAddress ^ 32'hC0DE_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    bit          st;
    logic [31:0] sa;
    logic [31:0] sd;
    bit          rdy;
    bit          e_empty;
    bit          e_full;
    bit          e_stall;
    bit          e_we;
  } vec_t;

  ent_t q[$];
  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return w ^ 32'hC0DE_0000;
  endfunction

  // One cycle: drive, sample at the falling edge against the model, then advance.
  task automatic cyc(input bit st, input logic [31:0] sa, input logic [31:0] sd,
                     input bit ld, input logic [31:0] la, input bit rdy,
                     output bit o_empty, output bit o_full, output bit o_stall, output bit o_we);
    int          n;
    bit          hit;
    logic [31:0] hd, exp_ld;
    bit          exp_stall;
    stWrEn = st; stAddr = sa; stData = sd;
    ldRdEn = ld; ldAddr = la; memReady = rdy;
    #4;
    n = q.size();
    hit = 1'b0;
    hd  = '0;
    foreach (q[i]) begin
      if (q[i].a[31:2] == la[31:2]) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    end
`ifdef SB_FORWARD_EN
    exp_stall = st && (n == int'(DEPTH));
    exp_ld    = !ld ? 32'h0 : (hit ? hd : mem_rd(la));
`else
    exp_stall = (st && (n == int'(DEPTH))) || (ld && hit);
    exp_ld    = ld ? mem_rd(la) : 32'h0;
`endif
    o_empty = empty; o_full = full; o_stall = stall; o_we = memWriteEn;
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == int'(DEPTH)));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("memWriteEn", 32'(memWriteEn), 32'((n > 0) && rdy));
    chk("memRdAddress", memRdAddress, {la[31:2], 2'b00});
    chk("ldData", ldData, exp_ld);
    if (memWriteEn && n > 0) begin
      chk("memAddress", memAddress, q[0].a);
      chk("memDataIn", memDataIn, q[0].d);
    end
    @(posedge clk);
    #1;
    if (n > 0 && rdy) void'(q.pop_front());
    if (st && n < int'(DEPTH)) q.push_back('{a: {sa[31:2], 2'b00}, d: sd});
  endtask

  task automatic rst_cyc(input bit st, input bit rdy);
    rst = 1'b1; stWrEn = st; stAddr = 32'h0000_0F00; stData = 32'hDEAD_BEEF;
    ldRdEn = 1'b0; ldAddr = '0; memReady = rdy;
    #4;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_memWriteEn", 32'(memWriteEn), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    bit e, f, s, w;
    tbl[0]  = '{1, 32'h1000, 32'hAAAA_0001, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 32'h1004, 32'hBBBB_0002, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 32'h0,    32'h0,         0, 0, 0, 0, 0};
    tbl[3]  = '{0, 32'h0,    32'h0,         1, 0, 0, 0, 1};
    tbl[4]  = '{0, 32'h0,    32'h0,         1, 0, 0, 0, 1};
    tbl[5]  = '{0, 32'h0,    32'h0,         0, 1, 0, 0, 0};
    tbl[6]  = '{1, 32'h4000, 32'h0000_00A0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 32'h4004, 32'h0000_00A1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 32'h4008, 32'h0000_00A2, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 32'h400C, 32'h0000_00A3, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 32'h4010, 32'h0000_00A4, 0, 0, 1, 1, 0};
    tbl[11] = '{1, 32'h4010, 32'h0000_00A4, 0, 0, 1, 1, 0};
    tbl[12] = '{1, 32'h4010, 32'h0000_00A4, 1, 0, 1, 1, 1};
    tbl[13] = '{1, 32'h4010, 32'h0000_00A4, 1, 0, 0, 0, 1};
    tbl[14] = '{0, 32'h0,    32'h0,         1, 0, 0, 0, 1};
    tbl[15] = '{0, 32'h0,    32'h0,         1, 0, 0, 0, 1};
    tbl[16] = '{0, 32'h0,    32'h0,         1, 0, 0, 0, 1};
    tbl[17] = '{0, 32'h0,    32'h0,         0, 1, 0, 0, 0};

    rst_cyc(1'b0, 1'b0);

    // Two-store drain and full/backpressure table.
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].st, tbl[i].sa, tbl[i].sd, 1'b0, 32'h0, tbl[i].rdy, e, f, s, w);
      chk($sformatf("tbl%0d_empty", i), 32'(e), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), 32'(f), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_stall", i), 32'(s), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_we", i), 32'(w), 32'(tbl[i].e_we));
    end

    // Same-address stores then a hitting load; the model holds the forwarding expectation.
    cyc(1'b1, 32'h2000, 32'h11, 1'b0, 32'h0, 1'b0, e, f, s, w);
    cyc(1'b1, 32'h2000, 32'h22, 1'b0, 32'h0, 1'b0, e, f, s, w);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h2002, 1'b0, e, f, s, w);
`ifdef SB_FORWARD_EN
    chk("fwd_hit_stall", 32'(s), 32'h0);
`else
    chk("nofwd_hit_stall", 32'(s), 32'h1);
`endif
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h2100, 1'b0, e, f, s, w);
    chk("miss_stall", 32'(s), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h2002, 1'b1, e, f, s, w);
    chk("hit_after_drain_stall", 32'(s), 32'h0);

    // Reset with pending stores discards them.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 1'b0, 32'h0, 1'b0, e, f, s, w);
    rst_cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, e, f, s, w);
      chk("post_rst_we", 32'(w), 32'h0);
    end

    // Pointer wrap with continuous push and drain.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h3000 + 32'(4 * i), 32'(i), 1'b0, 32'h0, 1'b1, e, f, s, w);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, e, f, s, w);
    chk("wrap_empty", 32'(empty), 32'h1);

    // Mixed random traffic over a small aliasing address set.
    for (int i = 0; i < 80; i++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 3));
      a = 32'h5000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      if (r == 0)
        cyc(1'b0, 32'h0, 32'h0, 1'b1, a, 1'($urandom_range(0, 1)), e, f, s, w);
      else if (r < 3)
        cyc(1'b1, a, $urandom, 1'b0, 32'h0, 1'($urandom_range(0, 1)), e, f, s, w);
      else
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'($urandom_range(0, 1)), e, f, s, w);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, e, f, s, w);
    chk("final_queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
